// File: rtl/ecc_dec_pipe_if.sv
// ecc_dec_pipe_if
// Handshake bundle around the SECDED decoder.
//   in_valid / in_ready / data_in / work_mod        : codeword side
//   out_valid / out_ready / data_out / num_of_errors : result side
// Modports:
//   master : the environment driving codewords and taking results
//   slave  : the decoder itself
interface ecc_dec_pipe_if #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
);
  logic                          in_valid;
  logic                          in_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_in;
  logic [1:0]                    work_mod;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_INFO_WIDTH-1:0]     data_out;
  logic [1:0]                    num_of_errors;

  modport master (
    output in_valid, data_in, work_mod, out_ready,
    input  in_ready, out_valid, data_out, num_of_errors
  );

  modport slave (
    input  in_valid, data_in, work_mod, out_ready,
    output in_ready, out_valid, data_out, num_of_errors
  );
endinterface

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe
// Two-stage SECDED decoder for the three codeword formats of the ECC
// datapath: mode 00 (k=4,p=4,n=8), 01 (k=11,p=5,n=16), 10 (k=26,p=6,n=32);
// mode 11 is reported as illegal.
// Codeword layout: {pad, info[k-1:0], parity[p-1:0]}.
// Stage 1 computes the syndrome, stage 2 corrects / classifies and registers
// the result. Both stages use valid/ready flow control; the pipeline accepts
// one word per cycle when downstream keeps out_ready high.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active high
//   bus   : ecc_dec_pipe_if.slave (codeword in, corrected info out)
// Optional build macro ECC_ERR_CNT_EN adds:
//   cnt_clr    : synchronous clear of both counters (wins over increment)
//   corr_cnt   : saturating count of results with num_of_errors = 1
//   uncorr_cnt : saturating count of results with num_of_errors = 2 or 3
module ecc_dec_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_dec_pipe_if.slave        bus
`ifdef ECC_ERR_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [15:0]          corr_cnt,
  output logic [15:0]          uncorr_cnt
`endif
);

  // Parity-check matrices, row 0 (overall parity) in the top bits.
  // Syndrome bit i is taken from H[i*n +: n], so the overall row lands in
  // the syndrome MSB.
  localparam logic [31:0]  H1 = 32'hFFE4_D2B1;
  localparam logic [79:0]  H2 = 80'hFFFF_FE08_F1C4_CDA2_AB61;
  localparam logic [191:0] H3 = 192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1;

  // ---------------------------------------------------------------------
  // Stage 1: syndrome
  // ---------------------------------------------------------------------
  logic [3:0] syn1;
  logic [4:0] syn2;
  logic [5:0] syn3;

  genvar gi, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_syn1
      assign syn1[gi] = ^(bus.data_in[7:0] & H1[gi*8 +: 8]);
    end
    for (gi = 0; gi < 5; gi++) begin : g_syn2
      assign syn2[gi] = ^(bus.data_in[15:0] & H2[gi*16 +: 16]);
    end
    for (gi = 0; gi < 6; gi++) begin : g_syn3
      assign syn3[gi] = ^(bus.data_in[31:0] & H3[gi*32 +: 32]);
    end
  endgenerate

  logic [5:0]                    syn_next;
  logic [MAX_CODEWORD_WIDTH-1:4] hi_mask;

  always_comb begin
    syn_next = '0;
    hi_mask  = '0;
    case (bus.work_mod)
      2'b00: begin
        syn_next = {2'b00, syn1};
        hi_mask  = 28'h000_000F;
      end
      2'b01: begin
        syn_next = {1'b0, syn2};
        hi_mask  = 28'h000_0FFF;
      end
      2'b10: begin
        syn_next = syn3;
        hi_mask  = 28'hFFF_FFFF;
      end
      default: begin
        syn_next = '0;
        hi_mask  = '0;
      end
    endcase
  end

  // Pipeline flow control. s1_load is algebraically !v1 | !v2 | out_ready,
  // so it doubles as in_ready.
  logic v1_reg;
  logic v2_reg;
  logic s1_load;
  logic s2_load;

  assign s2_load      = !v2_reg | bus.out_ready;
  assign s1_load      = !v1_reg | s2_load;
  assign bus.in_ready = s1_load;

  // Codeword bits [3:0] are parity in every mode; once the syndrome is
  // known they cannot influence the info field, so only bits [n-1:4]
  // travel to stage 2.
  logic [5:0]                    syn_reg;
  logic [MAX_CODEWORD_WIDTH-1:4] cw_reg;
  logic [1:0]                    mode_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      syn_reg  <= '0;
      cw_reg   <= '0;
      mode_reg <= 2'b00;
    end else if (s1_load) begin
      v1_reg <= bus.in_valid;
      if (bus.in_valid) begin
        syn_reg  <= syn_next;
        cw_reg   <= bus.data_in[MAX_CODEWORD_WIDTH-1:4] & hi_mask;
        mode_reg <= bus.work_mod;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: column match, correction, classification
  // ---------------------------------------------------------------------
  logic [7:0]  match1;
  logic [15:0] match2;
  logic [31:0] match3;

  // Column j of H is {H[(p-1)*n+j], ..., H[j]}; a syndrome equal to it
  // points at codeword bit j.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col1
      logic [3:0] col;
      for (gr = 0; gr < 4; gr++) begin : g_bit
        assign col[gr] = H1[gr*8 + gi];
      end
      assign match1[gi] = (syn_reg[3:0] == col);
    end
    for (gi = 0; gi < 16; gi++) begin : g_col2
      logic [4:0] col;
      for (gr = 0; gr < 5; gr++) begin : g_bit
        assign col[gr] = H2[gr*16 + gi];
      end
      assign match2[gi] = (syn_reg[4:0] == col);
    end
    for (gi = 0; gi < 32; gi++) begin : g_col3
      logic [5:0] col;
      for (gr = 0; gr < 6; gr++) begin : g_bit
        assign col[gr] = H3[gr*32 + gi];
      end
      assign match3[gi] = (syn_reg[5:0] == col);
    end
  endgenerate

  logic [31:0]                   flip;
  logic                          syn_top;
  logic                          correctable;
  logic [MAX_CODEWORD_WIDTH-1:4] corrected;
  logic [MAX_INFO_WIDTH-1:0]     data_next;
  logic [1:0]                    err_next;

  always_comb begin
    flip    = '0;
    syn_top = 1'b0;
    case (mode_reg)
      2'b00: begin
        flip    = {24'd0, match1};
        syn_top = syn_reg[3];
      end
      2'b01: begin
        flip    = {16'd0, match2};
        syn_top = syn_reg[4];
      end
      2'b10: begin
        flip    = match3;
        syn_top = syn_reg[5];
      end
      default: begin
        flip    = '0;
        syn_top = 1'b0;
      end
    endcase

    // Only an odd-weight syndrome that hits a column is a single-bit error;
    // a hit in the parity nibble still counts as corrected even though the
    // retained bits are unchanged.
    correctable = syn_top & (|flip);
    corrected   = correctable ? (cw_reg ^ flip[MAX_CODEWORD_WIDTH-1:4]) : cw_reg;

    data_next = '0;
    case (mode_reg)
      2'b00:   data_next = {22'd0, corrected[7:4]};
      2'b01:   data_next = {15'd0, corrected[15:5]};
      2'b10:   data_next = corrected[31:6];
      default: data_next = '0;
    endcase

    if (mode_reg == 2'b11) begin
      err_next = 2'd3;
    end else if (syn_reg == 6'd0) begin
      err_next = 2'd0;
    end else if (correctable) begin
      err_next = 2'd1;
    end else begin
      err_next = 2'd2;
    end
  end

  logic [MAX_INFO_WIDTH-1:0] data_reg;
  logic [1:0]                err_reg;

  // Result registers load only when a real word arrives, so an empty
  // stage 2 keeps presenting the last result with out_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_reg   <= 1'b0;
      data_reg <= '0;
      err_reg  <= 2'd0;
    end else if (s2_load) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        data_reg <= data_next;
        err_reg  <= err_next;
      end
    end
  end

  assign bus.out_valid     = v2_reg;
  assign bus.data_out      = data_reg;
  assign bus.num_of_errors = err_reg;

`ifdef ECC_ERR_CNT_EN
  // ---------------------------------------------------------------------
  // Error statistics, counted on output transfers
  // ---------------------------------------------------------------------
  logic        out_xfer;
  logic [15:0] corr_cnt_reg;
  logic [15:0] uncorr_cnt_reg;

  assign out_xfer = v2_reg & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_reg   <= 16'd0;
      uncorr_cnt_reg <= 16'd0;
    end else if (cnt_clr) begin
      corr_cnt_reg   <= 16'd0;
      uncorr_cnt_reg <= 16'd0;
    end else if (out_xfer) begin
      if ((err_reg == 2'd1) && (corr_cnt_reg != 16'hFFFF)) begin
        corr_cnt_reg <= corr_cnt_reg + 16'd1;
      end
      // errors 2 and 3 both have bit 1 set
      if (err_reg[1] && (uncorr_cnt_reg != 16'hFFFF)) begin
        uncorr_cnt_reg <= uncorr_cnt_reg + 16'd1;
      end
    end
  end

  assign corr_cnt   = corr_cnt_reg;
  assign uncorr_cnt = uncorr_cnt_reg;
`endif

endmodule
